// File: rtl/rx_cmd_ctrl.sv
// rx_cmd_ctrl
//   Turns UART receive bytes into register-file commands.
//   Write frame: 0xAA, address, data. The register file gets one WrEn pulse.
//   Read frame:  0xBB, address. The register file gets one RdEn pulse. The
//                returned RdData is handed to the transmitter with TX_D_VLD.
//   A byte with a parity or framing error, an unknown command byte, or a stall
//   longer than TIMEOUT cycles abandons the frame and pulses cmd_err.
//
// Ports
//   CLK, RST          clock; asynchronous active-high reset
//   RX_P_DATA/RX_D_VLD, RX_PAR_ERR/RX_FRM_ERR   receive byte, its strobe and its error flags
//   RdData/RdData_Valid                          read data returned by the register file
//   TX_Busy                                      transmitter busy level
//   Address, WrEn, WrData, RdEn                  register-file command outputs
//   TX_P_DATA, TX_D_VLD                          byte handed to the transmitter
//   cmd_err                                      one-cycle protocol error pulse
module rx_cmd_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic                  RX_PAR_ERR,
  input  logic                  RX_FRM_ERR,
  input  logic [7:0]            RdData,
  input  logic                  RdData_Valid,
  input  logic                  TX_Busy,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic                  WrEn,
  output logic [7:0]            WrData,
  output logic                  RdEn,
  output logic [7:0]            TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic                  cmd_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        tmo_cnt_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              wr_data_q;
  logic [7:0]              tx_data_q;
  logic                    wr_en_q;
  logic                    rd_en_q;
  logic                    tx_vld_q;
  logic                    cmd_err_q;

  logic byte_ok;
  logic byte_bad;
  logic tmo_hit;
  logic counting;

  assign byte_ok  = RX_D_VLD & ~RX_PAR_ERR & ~RX_FRM_ERR;
  assign byte_bad = RX_D_VLD & (RX_PAR_ERR | RX_FRM_ERR);
  assign tmo_hit  = (tmo_cnt_q == CNT_W'(TIMEOUT));
  assign counting = (state_q == WR_ADDR) || (state_q == WR_DATA) ||
                    (state_q == RD_ADDR) || (state_q == RD_WAIT);

  // Every transition below also clears the timeout counter; the later
  // non-blocking assignment overrides the increment.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      tmo_cnt_q <= '0;
      addr_q    <= '0;
      wr_data_q <= '0;
      tx_data_q <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      tx_vld_q  <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      tx_vld_q  <= 1'b0;
      cmd_err_q <= 1'b0;
      if (counting && !tmo_hit) begin
        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
      end

      case (state_q)
        IDLE: begin
          if (byte_ok && RX_P_DATA == 8'hAA) begin
            state_q   <= WR_ADDR;
            tmo_cnt_q <= '0;
          end else if (byte_ok && RX_P_DATA == 8'hBB) begin
            state_q   <= RD_ADDR;
            tmo_cnt_q <= '0;
          end else if (RX_D_VLD) begin
            // Unknown command or errored byte: report it and stay put.
            cmd_err_q <= 1'b1;
          end
        end

        WR_ADDR, WR_DATA, RD_ADDR: begin
          if (byte_ok) begin
            tmo_cnt_q <= '0;
            if (state_q == WR_ADDR) begin
              addr_q  <= RX_P_DATA[ADDR_WIDTH-1:0];
              state_q <= WR_DATA;
            end else if (state_q == WR_DATA) begin
              wr_data_q <= RX_P_DATA;
              wr_en_q   <= 1'b1;
              state_q   <= IDLE;
            end else begin
              addr_q  <= RX_P_DATA[ADDR_WIDTH-1:0];
              rd_en_q <= 1'b1;
              state_q <= RD_WAIT;
            end
          end else if (byte_bad || tmo_hit) begin
            cmd_err_q <= 1'b1;
            state_q   <= IDLE;
            tmo_cnt_q <= '0;
          end
        end

        RD_WAIT: begin
          // A stray byte is dropped and reported, but the read stays pending.
          if (RX_D_VLD) begin
            cmd_err_q <= 1'b1;
          end
          if (RdData_Valid) begin
            tx_data_q <= RdData;
            state_q   <= TX_SEND;
            tmo_cnt_q <= '0;
          end else if (!RX_D_VLD && tmo_hit) begin
            cmd_err_q <= 1'b1;
            state_q   <= IDLE;
            tmo_cnt_q <= '0;
          end
        end

        TX_SEND: begin
          // No timeout here: a busy transmitter may hold us indefinitely.
          if (RX_D_VLD) begin
            cmd_err_q <= 1'b1;
          end
          if (!TX_Busy) begin
            tx_vld_q  <= 1'b1;
            state_q   <= IDLE;
            tmo_cnt_q <= '0;
          end
        end

        default: begin
          state_q   <= IDLE;
          tmo_cnt_q <= '0;
        end
      endcase
    end
  end

  assign Address   = addr_q;
  assign WrEn      = wr_en_q;
  assign WrData    = wr_data_q;
  assign RdEn      = rd_en_q;
  assign TX_P_DATA = tx_data_q;
  assign TX_D_VLD  = tx_vld_q;
  assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_rx_cmd_ctrl.sv
// Scoreboard bench for rx_cmd_ctrl. Each expected strobe (kind, payload and
// the cycle window it must land in) is queued when the stimulus is driven. A
// negedge monitor pops one entry for every strobe the DUT raises.
module tb_rx_cmd_ctrl;

  localparam int AW  = 4;
  localparam int TMO = 1023;

  localparam int K_WR  = 0;
  localparam int K_RD  = 1;
  localparam int K_TX  = 2;
  localparam int K_ERR = 3;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [7:0]    RX_P_DATA = '0;
  logic          RX_D_VLD = 1'b0;
  logic          RX_PAR_ERR = 1'b0;
  logic          RX_FRM_ERR = 1'b0;
  logic [7:0]    RdData = '0;
  logic          RdData_Valid = 1'b0;
  logic          TX_Busy = 1'b0;
  logic [AW-1:0] Address;
  logic          WrEn;
  logic [7:0]    WrData;
  logic          RdEn;
  logic [7:0]    TX_P_DATA;
  logic          TX_D_VLD;
  logic          cmd_err;

  rx_cmd_ctrl #(.ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_P_DATA    (RX_P_DATA),
    .RX_D_VLD     (RX_D_VLD),
    .RX_PAR_ERR   (RX_PAR_ERR),
    .RX_FRM_ERR   (RX_FRM_ERR),
    .RdData       (RdData),
    .RdData_Valid (RdData_Valid),
    .TX_Busy      (TX_Busy),
    .Address      (Address),
    .WrEn         (WrEn),
    .WrData       (WrData),
    .RdEn         (RdEn),
    .TX_P_DATA    (TX_P_DATA),
    .TX_D_VLD     (TX_D_VLD),
    .cmd_err      (cmd_err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    logic [31:0] val;
    int          lo;
    int          hi;
  } ev_t;

  ev_t sb[$];
  int  n_chk = 0;
  int  n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [31:0] val, input int lo, input int hi);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.lo   = lo;
    e.hi   = hi;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic perr = 1'b0, input logic ferr = 1'b0);
    RX_P_DATA  = b;
    RX_PAR_ERR = perr;
    RX_FRM_ERR = ferr;
    RX_D_VLD   = 1'b1;
    step();
    RX_D_VLD   = 1'b0;
    RX_PAR_ERR = 1'b0;
    RX_FRM_ERR = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic observe(input int kind, input logic [31:0] val);
    ev_t e;
    if (sb.size() == 0) begin
      chk("unexpected_strobe", kind, 99);
    end else begin
      e = sb.pop_front();
      chk("strobe_kind", kind, e.kind);
      chk("strobe_val", val, e.val);
      chk("strobe_cycle", (cyc >= e.lo && cyc <= e.hi), 1);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      if (WrEn)     observe(K_WR, 32'({Address, WrData}));
      if (RdEn)     observe(K_RD, 32'(Address));
      if (TX_D_VLD) observe(K_TX, 32'(TX_P_DATA));
      if (cmd_err)  observe(K_ERR, 32'd0);
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"},  32'(Address),   0);
    chk({tag, "_wren"},  32'(WrEn),      0);
    chk({tag, "_wdata"}, 32'(WrData),    0);
    chk({tag, "_rden"},  32'(RdEn),      0);
    chk({tag, "_txd"},   32'(TX_P_DATA), 0);
    chk({tag, "_txv"},   32'(TX_D_VLD),  0);
    chk({tag, "_err"},   32'(cmd_err),   0);
  endtask

  initial begin
    #3;
    chk_all_zero("reset");
    step();
    step();
    RST = 1'b0;
    step();

    // Plain write
    send_byte(8'hAA);
    send_byte(8'h05);
    expect_ev(K_WR, 32'h53C, cyc + 1, cyc + 1);
    send_byte(8'h3C);
    drain(20);
    chk("hold_addr", 32'(Address), 32'h5);
    chk("hold_wdata", 32'(WrData), 32'h3C);

    // Unknown command byte
    expect_ev(K_ERR, 0, cyc + 1, cyc + 1);
    send_byte(8'h55);
    drain(20);

    // Parity error on the address byte, then a clean write
    send_byte(8'hAA);
    expect_ev(K_ERR, 0, cyc + 1, cyc + 1);
    send_byte(8'h05, 1'b1, 1'b0);
    send_byte(8'hAA);
    send_byte(8'h01);
    expect_ev(K_WR, 32'h111, cyc + 1, cyc + 1);
    send_byte(8'h11);
    drain(20);

    // Framing error on the data byte: no write happens, WrData is kept
    send_byte(8'hAA);
    send_byte(8'h03);
    expect_ev(K_ERR, 0, cyc + 1, cyc + 1);
    send_byte(8'h44, 1'b0, 1'b1);
    drain(20);
    chk("wdata_kept", 32'(WrData), 32'h11);

    // Read: data returns 3 cycles after RdEn, transmitter busy for 10 cycles
    send_byte(8'hBB);
    expect_ev(K_RD, 32'h2, cyc + 1, cyc + 1);
    send_byte(8'h02);
    step();
    step();
    step();
    RdData       = 8'h7E;
    RdData_Valid = 1'b1;
    TX_Busy      = 1'b1;
    step();
    RdData_Valid = 1'b0;
    RdData       = 8'h00;
    for (int i = 0; i < 9; i++) begin
      step();
      if (i == 4) chk("tx_data_stable", 32'(TX_P_DATA), 32'h7E);
    end
    TX_Busy = 1'b0;
    expect_ev(K_TX, 32'h7E, cyc + 1, cyc + 1);
    step();
    drain(20);

    // Stray byte while waiting for read data is dropped; the read still completes
    send_byte(8'hBB);
    expect_ev(K_RD, 32'h9, cyc + 1, cyc + 1);
    send_byte(8'h09);
    expect_ev(K_ERR, 0, cyc + 1, cyc + 1);
    send_byte(8'h42);
    RdData       = 8'hC3;
    RdData_Valid = 1'b1;
    expect_ev(K_TX, 32'hC3, cyc + 2, cyc + 2);
    step();
    RdData_Valid = 1'b0;
    drain(20);

    // Back-to-back write then read, no idle cycles between strobes
    send_byte(8'hAA);
    send_byte(8'h0A);
    expect_ev(K_WR, 32'hAF0, cyc + 1, cyc + 1);
    send_byte(8'hF0);
    send_byte(8'hBB);
    expect_ev(K_RD, 32'hB, cyc + 1, cyc + 1);
    send_byte(8'h0B);
    RdData       = 8'h5A;
    RdData_Valid = 1'b1;
    expect_ev(K_TX, 32'h5A, cyc + 2, cyc + 2);
    step();
    RdData_Valid = 1'b0;
    drain(20);

    // Timeout after a write command byte, then a write still works
    expect_ev(K_ERR, 0, cyc + 1 + TMO, cyc + 2 + TMO);
    send_byte(8'hAA);
    drain(TMO + 20);
    send_byte(8'hAA);
    send_byte(8'h07);
    expect_ev(K_WR, 32'h7E1, cyc + 1, cyc + 1);
    send_byte(8'hE1);
    drain(20);

    // Reset between read command and address byte
    send_byte(8'hBB);
    #2;
    RST = 1'b1;
    #1;
    chk_all_zero("midreset");
    step();
    chk_all_zero("midreset_clk");
    RST = 1'b0;
    expect_ev(K_ERR, 0, cyc + 1, cyc + 1);
    send_byte(8'h02);
    drain(20);

    // Quiet tail: any spurious strobe is flagged by the monitor
    repeat (20) step();
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
